execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the pipelined RV32I core, plus an RV32M `MUL` extension. It consumes every field the decode→execute pipeline register launches. It performs ALU, branch and jump resolution, and captures results into the execute→memory pipeline register. `MUL` runs on a 32-iteration shift-add FSM that raises `BusyE` so the hazard unit holds fetch, decode and the decode→execute register until the product is ready.

## Interface
- `WIDTH`, 32, datapath width; `MUL` iteration count equals `WIDTH`.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `RegWriteE`, `MemWriteE`, `JumpE`, `BranchE`, `ALUSrcE`, `JumpRegE` in 1: control bits from the decode→execute register. `JumpRegE` marks JALR.
- `ResultSrcE` in 2: writeback select, passed through.
- `ALUControlE` in 4: operation code (see Operation).
- `BranchTypeE` in 3: branch funct3.
- `RD1E`, `RD2E`, `ImmExtE`, `PCE`, `PCPlus4E` in WIDTH: operands, immediate and PCs.
- `RdE` in 5: destination register.
- `PCSrcE` out 1: redirect fetch. Combinational.
- `PCTargetE` out WIDTH: redirect address. Combinational.
- `BusyE` out 1: stall request. Combinational from FSM state and `ALUControlE`.
- `RegWriteM`, `MemWriteM` out 1: registered.
- `ResultSrcM` out 2: registered.
- `ALUResultM`, `WriteDataM`, `PCPlus4M` out WIDTH: registered.
- `RdM` out 5: registered.

## Operation
- `SrcA` = `RD1E`. `SrcB` = `ALUSrcE` ? `ImmExtE` : `RD2E`.
- `ALUControlE` codes:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 slt (signed), 0110 sltu. Both give 1 or 0, zero-extended.
  - 0111 sll, 1000 srl, 1001 sra. Shift amount is `SrcB[4:0]`.
  - 1010 pass `SrcB` (LUI).
  - 1111 mul: low `WIDTH` bits of `SrcA`*`SrcB`; signedness irrelevant.
  - Other codes yield 0.
- Branch condition from `BranchTypeE`, comparing `RD1E` vs `RD2E`:
  - 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 ltu, 111 geu.
  - 010/011 never taken.
- `PCSrcE` = `JumpE` | (`BranchE` & condition).
- `PCTargetE` = `JumpRegE` ? ((`RD1E`+`ImmExtE`) & ~1) : (`PCE`+`ImmExtE`). Additions wrap modulo 2^WIDTH.
- Multiply FSM:
  - States IDLE, MUL, DONE; 5-bit iteration counter; `WIDTH`-bit accumulator, multiplicand and multiplier registers.
  - IDLE and `ALUControlE`==1111: load multiplicand=`SrcA`, multiplier=`SrcB`, acc=0, cnt=0, go to MUL.
  - MUL: if multiplier[0], acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, cnt++. When cnt==31 on this cycle, go to DONE.
  - DONE: product = acc, go to IDLE unconditionally. `ALUControlE` is ignored, so the still-held `MUL` does not retrigger.
- `BusyE` = (IDLE & `ALUControlE`==1111) | MUL. `BusyE` is 0 in DONE.
- Execute→memory register, each posedge:
  - `rst` → all outputs 0.
  - `BusyE`=1 → bubble: all outputs 0.
  - Otherwise capture `RegWriteE`, `ResultSrcE`, `MemWriteE`, the ALU result (accumulator in DONE), `RD2E`→`WriteDataM`, `RdE`, `PCPlus4E`.
- Branch/jump resolution does not depend on `BusyE`. `MUL` decodes with `JumpE`=`BranchE`=0, so `PCSrcE`=0 throughout.

## Timing
- Non-`MUL` ops: `PCSrcE`/`PCTargetE` valid in the same cycle. M outputs update at the next posedge: 1-cycle latency.
- `MUL` issued at cycle 0:
  - `BusyE`=1 in cycles 0–32 (33 cycles).
  - DONE in cycle 33: `BusyE`=0.
  - `ALUResultM`=product after the posedge ending cycle 33.
  - Total occupancy of execute: 34 cycles.
- Back-to-back `MUL`: the second enters execute at cycle 34 in IDLE and starts a fresh 34-cycle sequence. No overlap.
- `rst` asserted mid-`MUL`: next posedge gives state IDLE, cnt=0, acc=0, all M outputs 0. `BusyE` follows the new `ALUControlE`.
- Reset values: all registered outputs 0, FSM IDLE.

## Test plan
- add: `RD1E`=5, `RD2E`=7, `ALUSrcE`=0, `RegWriteE`=1, `RdE`=3 → next cycle `ALUResultM`=12, `RdM`=3, `RegWriteM`=1.
- beq taken: `BranchE`=1, type 000, `RD1E`=`RD2E`=9, `PCE`=0x100, `ImmExtE`=0x20 → same cycle `PCSrcE`=1, `PCTargetE`=0x120. With `RD2E`=8 → `PCSrcE`=0.
- JALR: `JumpE`=`JumpRegE`=1, `RD1E`=0x1003, `ImmExtE`=0 → `PCTargetE`=0x1002, `PCSrcE`=1, `PCPlus4M` captured.
- slt/sltu: `RD1E`=0xFFFFFFFF, `RD2E`=1 → slt gives 1, sltu gives 0.
- `MUL` 7×6, then 0xFFFFFFFF×2, held in decode→execute:
  - `BusyE` high exactly 33 cycles; `RegWriteM`=0 during busy.
  - Then `ALUResultM`=42 with `RegWriteM`=1.
  - Second product 0xFFFFFFFE.
- Reset at cycle 10 of a `MUL` → next cycle all M outputs 0. With `ALUControlE` changed to add, `BusyE`=0 and the add completes normally.

Source files
------------

// File: rtl/execute_stage.sv
// execute_stage: RV32I ALU/branch/jump resolution with a shift-add MUL FSM and the execute->memory register
module execute_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             JumpE,
  input  logic             BranchE,
  input  logic             ALUSrcE,
  input  logic             JumpRegE,
  input  logic [1:0]       ResultSrcE,
  input  logic [3:0]       ALUControlE,
  input  logic [2:0]       BranchTypeE,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] ImmExtE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic [4:0]       RdE,
  output logic             PCSrcE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic             BusyE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [1:0]       ResultSrcM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] PCPlus4M,
  output logic [4:0]       RdM
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state, stateNext;
  logic [4:0] cnt;
  logic [WIDTH-1:0] acc, mcand, mplier, srcB, aluResult, jalrSum;
  logic isMul, eq, lt, ltu, cond;
  assign srcB = ALUSrcE ? ImmExtE : RD2E;
  assign isMul = ALUControlE == 4'b1111;
  always_comb begin
    case (ALUControlE)
      4'b0000: aluResult = RD1E + srcB;
      4'b0001: aluResult = RD1E - srcB;
      4'b0010: aluResult = RD1E & srcB;
      4'b0011: aluResult = RD1E | srcB;
      4'b0100: aluResult = RD1E ^ srcB;
      4'b0101: aluResult = {{(WIDTH-1){1'b0}}, $signed(RD1E) < $signed(srcB)};
      4'b0110: aluResult = {{(WIDTH-1){1'b0}}, RD1E < srcB};
      4'b0111: aluResult = RD1E << srcB[4:0];
      4'b1000: aluResult = RD1E >> srcB[4:0];
      4'b1001: aluResult = $signed(RD1E) >>> srcB[4:0];
      4'b1010: aluResult = srcB;
      default: aluResult = '0;
    endcase
  end
  assign eq = RD1E == RD2E;
  assign lt = $signed(RD1E) < $signed(RD2E);
  assign ltu = RD1E < RD2E;
  always_comb begin
    case (BranchTypeE)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt;
      3'b101:  cond = !lt;
      3'b110:  cond = ltu;
      3'b111:  cond = !ltu;
      default: cond = 1'b0;
    endcase
  end
  assign PCSrcE = JumpE | (BranchE & cond);
  assign jalrSum = RD1E + ImmExtE;
  assign PCTargetE = JumpRegE ? {jalrSum[WIDTH-1:1], 1'b0} : PCE + ImmExtE;
  assign BusyE = (state == IDLE && isMul) || state == MUL;
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = isMul ? MUL : IDLE;
      MUL:     stateNext = cnt == 5'd31 ? DONE : MUL;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= rst ? IDLE : stateNext;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (state == IDLE && isMul) begin
      cnt <= '0;
      acc <= '0;
      mcand <= RD1E;
      mplier <= srcB;
    end else if (state == MUL) begin
      cnt <= cnt + 5'd1;
      acc <= acc + (mplier[0] ? mcand : '0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
  // A stalled MUL sends bubbles downstream; the product leaves from DONE
  always_ff @(posedge clk) begin
    if (rst || BusyE) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      ResultSrcM <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M <= '0;
      RdM <= '0;
    end else begin
      RegWriteM <= RegWriteE;
      MemWriteM <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= state == DONE ? acc : aluResult;
      WriteDataM <= RD2E;
      PCPlus4M <= PCPlus4E;
      RdM <= RdE;
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors with a queue scoreboard checking the execute->memory register
module tb_execute_stage;
  logic clk = 0, rst;
  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JumpRegE;
  logic [1:0] ResultSrcE;
  logic [3:0] ALUControlE;
  logic [2:0] BranchTypeE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] RdE;
  logic PCSrcE, BusyE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [1:0] ResultSrcM;
  logic [4:0] RdM;
  int errors = 0, checks = 0;
  logic [104:0] qv[$];
  string qn[$];

  execute_stage dut (
    .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .JumpRegE(JumpRegE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .BranchTypeE(BranchTypeE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .BusyE(BusyE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [104:0] rec(input logic rw, input logic mw, input logic [1:0] rs,
      input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc4);
    return {rw, mw, rs, alu, wd, rd, pc4};
  endfunction

  // Monitor: each posedge produces one M record, matched against the oldest expectation
  initial forever begin
    @(posedge clk);
    #1;
    if (qv.size() > 0)
      check(qn.pop_front(), 128'({RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus4M}),
            128'(qv.pop_front()));
  end

  task automatic clr();
    {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JumpRegE} = '0;
    ResultSrcE = 0; ALUControlE = 0; BranchTypeE = 0;
    RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; RdE = 0;
  endtask

  task automatic cyc(input logic [104:0] e, input logic busy, input string n);
    #1;
    check({n, " busy"}, 128'(BusyE), 128'(busy));
    qv.push_back(e);
    qn.push_back(n);
    @(negedge clk);
  endtask

  task automatic redirect(input string n, input logic s, input logic [31:0] t);
    #1;
    check({n, " PCSrcE"}, 128'(PCSrcE), 128'(s));
    if (s) check({n, " PCTargetE"}, 128'(PCTargetE), 128'(t));
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input string n);
    clr();
    ALUControlE = op; RD1E = a; ALUSrcE = 1; ImmExtE = b; RD2E = 32'h5A;
    RegWriteE = 1; RdE = 7;
    cyc(rec(1, 0, 0, exp, 32'h5A, 7, 0), 0, n);
  endtask

  task automatic branch(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic taken, input string n);
    clr();
    BranchE = 1; BranchTypeE = t; RD1E = a; RD2E = b; PCE = 32'h100; ImmExtE = 32'h20;
    redirect(n, taken, 32'h120);
    cyc(rec(0, 0, 0, a + b, b, 0, 0), 0, n);
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p, input string n);
    clr();
    ALUControlE = 4'hF; RD1E = a; RD2E = b; RegWriteE = 1; RdE = 5; PCPlus4E = 32'h300;
    for (int i = 0; i < 33; i++) cyc('0, 1, {n, " stall"});
    cyc(rec(1, 0, 0, p, b, 5, 32'h300), 0, {n, " done"});
  endtask

  initial begin
    clr();
    rst = 1;
    cyc('0, 0, "reset");
    rst = 0;
    RD1E = 5; RD2E = 7; RegWriteE = 1; RdE = 3; PCPlus4E = 32'h44;
    cyc(rec(1, 0, 0, 12, 7, 3, 32'h44), 0, "add reg");
    clr();
    ALUControlE = 1; RD1E = 10; ALUSrcE = 1; ImmExtE = 3; RD2E = 32'h55; ResultSrcE = 1;
    RegWriteE = 1; RdE = 4;
    cyc(rec(1, 0, 1, 7, 32'h55, 4, 0), 0, "sub imm");
    clr();
    MemWriteE = 1; ALUSrcE = 1; RD1E = 32'h100; ImmExtE = 8; RD2E = 32'hDEAD;
    cyc(rec(0, 1, 0, 32'h108, 32'hDEAD, 0, 0), 0, "store");
    branch(3'b000, 9, 9, 1, "beq taken");
    branch(3'b000, 9, 8, 0, "beq not taken");
    branch(3'b001, 9, 8, 1, "bne taken");
    branch(3'b100, 32'hFFFFFFFF, 1, 1, "blt");
    branch(3'b101, 32'hFFFFFFFF, 1, 0, "bge");
    branch(3'b110, 32'hFFFFFFFF, 1, 0, "bltu");
    branch(3'b111, 32'hFFFFFFFF, 1, 1, "bgeu");
    branch(3'b010, 9, 9, 0, "type 010");
    branch(3'b011, 9, 8, 0, "type 011");
    clr();
    JumpE = 1; JumpRegE = 1; RD1E = 32'h1003; ALUSrcE = 1; PCPlus4E = 32'h208;
    RegWriteE = 1; ResultSrcE = 2; RdE = 1;
    redirect("jalr", 1, 32'h1002);
    cyc(rec(1, 0, 2, 32'h1003, 0, 1, 32'h208), 0, "jalr");
    clr();
    JumpE = 1; JumpRegE = 1; RD1E = 32'h2000; ImmExtE = 32'hFFFFFFFD; ALUSrcE = 1;
    redirect("jalr neg imm", 1, 32'h1FFC);
    cyc(rec(0, 0, 0, 32'h1FFD, 0, 0, 0), 0, "jalr neg imm");
    clr();
    JumpE = 1; PCE = 32'hFFFFFFF0; ImmExtE = 32'h20; PCPlus4E = 32'hFFFFFFF4;
    redirect("jal wrap", 1, 32'h10);
    cyc(rec(0, 0, 0, 0, 0, 0, 32'hFFFFFFF4), 0, "jal wrap");
    alu(4'b0101, 32'hFFFFFFFF, 1, 1, "slt");
    alu(4'b0110, 32'hFFFFFFFF, 1, 0, "sltu");
    alu(4'b0010, 32'hF0F0, 32'hFF00, 32'hF000, "and");
    alu(4'b0011, 32'hF0F0, 32'hFF00, 32'hFFF0, "or");
    alu(4'b0100, 32'hF0F0, 32'hFF00, 32'h0FF0, "xor");
    alu(4'b0111, 32'h80000001, 32'h24, 32'h10, "sll");
    alu(4'b1000, 32'h80000000, 4, 32'h08000000, "srl");
    alu(4'b1001, 32'h80000000, 4, 32'hF8000000, "sra");
    alu(4'b1010, 32'h1, 32'h12345000, 32'h12345000, "lui");
    alu(4'b1011, 32'h1, 32'h2, 0, "unused op");
    run_mul(7, 6, 42, "mul 7x6");
    run_mul(32'hFFFFFFFF, 2, 32'hFFFFFFFE, "mul ffffffffx2");
    clr();
    ALUControlE = 4'hF; RD1E = 3; RD2E = 4; RegWriteE = 1; RdE = 5; PCPlus4E = 32'h300;
    for (int i = 0; i < 10; i++) cyc('0, 1, "mul pre-reset");
    rst = 1;
    cyc('0, 1, "reset mid mul");
    rst = 0;
    ALUControlE = 0;
    cyc(rec(1, 0, 0, 7, 4, 5, 32'h300), 0, "add after reset");
    run_mul(32'h12345, 32'h10, 32'h123450, "mul after reset");
    clr();
    cyc('0, 0, "idle");
    for (int i = 0; i < 5 && qv.size() > 0; i++) @(negedge clk);
    if (qv.size() > 0) check("drain", 128'(qv.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
